ps2_rx_fifo: RTL and testbench

//  PS/2 device-to-host receiver: samples the ps2_clk/ps2_data pins and deframes 11-bit frames.

---
 rtl/ps2_pkg.sv | 13 +
 rtl/ps2_sync_edge.sv | 32 +++
 rtl/ps2_rx_fifo.sv | 88 ++++++++
 tb/tb_ps2_rx_fifo.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg: PS/2 frame layout, shared scan-code constants and the frame check
package ps2_pkg;
  localparam int FRAME_BITS = 11;
  localparam logic [3:0] START_BIT = 4'd0;
  localparam logic [3:0] PARITY_BIT = 4'd9;
  localparam logic [3:0] STOP_BIT = 4'd10;
  localparam logic [7:0] BREAK_CODE = 8'hF0;
  localparam logic [7:0] EXT_CODE = 8'hE0;
  // f holds bits 0..9 of a frame (start, data, parity); stop is the live bit-10 sample
  function automatic logic frame_ok(input logic [9:0] f, input logic stop);
    return !f[START_BIT] && stop && (^f[PARITY_BIT:1]);
  endfunction
endpackage

// File: rtl/ps2_sync_edge.sv
// ps2_sync_edge: synchronises the PS/2 pins into clk and produces a registered ps2_clk fall strobe
module ps2_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_ps2_clk,
  input  logic i_ps2_data,
  output logic o_fall,
  output logic o_bit
);
  logic [SYNC_STAGES-1:0] r_clk_s, r_dat_s;
  logic r_clk_d, r_fall, r_bit;
  // synchroniser chains, previous-clk flop, and fall/data registered together so they stay aligned
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_clk_s <= '0;
      r_dat_s <= '0;
      r_clk_d <= 1'b0;
      r_fall <= 1'b0;
      r_bit <= 1'b0;
    end else begin
      r_clk_s <= {r_clk_s[SYNC_STAGES-2:0], i_ps2_clk};
      r_dat_s <= {r_dat_s[SYNC_STAGES-2:0], i_ps2_data};
      r_clk_d <= r_clk_s[SYNC_STAGES-1];
      r_fall <= r_clk_d & ~r_clk_s[SYNC_STAGES-1];
      r_bit <= r_dat_s[SYNC_STAGES-1];
    end
  end
  assign o_fall = r_fall;
  assign o_bit = r_bit;
endmodule

// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: PS/2 device-to-host deframer feeding a small byte FIFO with edge-triggered pop
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH_LOG2 = 3,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       nextdata_n,
  output logic [7:0] data,
  output logic       ready,
  output logic       overflow,
  output logic       frame_err
);
  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYC);
  logic w_fall, w_bit, w_last, w_ok, w_push, w_empty, w_full, w_pop, w_wr, w_timeout;
  logic [$clog2(FRAME_BITS)-1:0] r_bit_cnt;
  logic [9:0] r_frame;
  logic [TW-1:0] r_to;
  logic [DEPTH_LOG2:0] r_wptr, r_rptr;
  logic [7:0] r_mem [DEPTH];
  logic r_nd_d1, r_overflow, r_frame_err;
  ps2_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk(clk),
    .rst(rst),
    .i_ps2_clk(ps2_clk),
    .i_ps2_data(ps2_data),
    .o_fall(w_fall),
    .o_bit(w_bit)
  );
  assign w_last = w_fall && (r_bit_cnt == STOP_BIT);
  assign w_ok = frame_ok(r_frame, w_bit);
  assign w_push = w_last & w_ok;
  assign w_timeout = !w_fall && (r_bit_cnt != '0) && (r_to == TO_MAX);
  assign w_empty = (r_wptr == r_rptr);
  assign w_full = (r_wptr[DEPTH_LOG2] != r_rptr[DEPTH_LOG2]) && (r_wptr[DEPTH_LOG2-1:0] == r_rptr[DEPTH_LOG2-1:0]);
  assign w_pop = ~w_empty & ~nextdata_n & r_nd_d1;
  assign w_wr = w_push & (~w_full | w_pop);
  // deframer: shift bits in on each fall, check at bit 10, abandon a stalled frame on timeout
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bit_cnt <= '0;
      r_frame <= '0;
      r_to <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= (w_last & ~w_ok) | w_timeout;
      if (w_fall) begin
        r_frame <= {w_bit, r_frame[9:1]};
        r_bit_cnt <= (r_bit_cnt == STOP_BIT) ? '0 : r_bit_cnt + 1'b1;
        r_to <= '0;
      end else if (w_timeout) begin
        r_bit_cnt <= '0;
        r_to <= '0;
      end else begin
        r_to <= (r_bit_cnt != '0) ? r_to + 1'b1 : '0;
      end
    end
  end
  // FIFO storage and pointers; a pop in the same cycle frees the slot for a push into a full FIFO
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_overflow <= 1'b0;
      r_nd_d1 <= 1'b1;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      r_nd_d1 <= nextdata_n;
      if (w_wr) begin
        r_mem[r_wptr[DEPTH_LOG2-1:0]] <= r_frame[8:1];
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      if (w_push & w_full & ~w_pop) r_overflow <= 1'b1;
    end
  end
  assign data = r_mem[r_rptr[DEPTH_LOG2-1:0]];
  assign ready = ~w_empty;
  assign overflow = r_overflow;
  assign frame_err = r_frame_err;
endmodule

// File: tb/tb_ps2_rx_fifo.sv
// tb_ps2_rx_fifo: directed and randomized PS/2 frames checked against a queue-based byte model
module tb_ps2_rx_fifo;
  localparam int S = 2;
  localparam int DL = 3;
  localparam int TO = 300;
  localparam int H = 10;
  logic clk = 0, rst = 1, ps2_clk = 1, ps2_data = 1, nextdata_n = 1;
  logic [7:0] data;
  logic ready, overflow, frame_err;
  int errors = 0, checks = 0, ferr_seen = 0, ferr_exp = 0, lat = 0;
  logic [7:0] mq[$];
  bit movf = 0;
  always #5 clk = ~clk;
  ps2_rx_fifo #(.DEPTH_LOG2(DL), .SYNC_STAGES(S), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .nextdata_n(nextdata_n),
    .data(data), .ready(ready), .overflow(overflow), .frame_err(frame_err)
  );
  always @(negedge clk) if (frame_err === 1'b1) ferr_seen++;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  function automatic logic [10:0] mk(input logic [7:0] b, input logic perr, input logic serr, input logic sterr);
    return {~sterr, ~(^b) ^ perr, b, serr};
  endfunction
  task automatic wn(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic send(input logic [10:0] f, input int nbits, input bit spop);
    for (int i = 0; i < nbits; i++) begin
      ps2_data = f[i];
      wn(H);
      ps2_clk = 0;
      for (int j = 1; j <= H; j++) begin
        @(negedge clk);
        if (i == 10) begin
          if (ready && lat == 0) lat = j;
          if (spop && j == 3) nextdata_n = 0;
          if (spop && j == 5) nextdata_n = 1;
        end
      end
      ps2_clk = 1;
    end
    ps2_data = 1;
    wn(2);
  endtask
  task automatic rx(input logic [7:0] b, input bit perr, input bit serr, input bit sterr, input bit spop);
    send(mk(b, perr, serr, sterr), 11, spop);
    if (spop && mq.size() > 0) void'(mq.pop_front());
    if (perr | serr | sterr) ferr_exp++;
    else if (mq.size() < 2 ** DL) mq.push_back(b);
    else movf = 1;
  endtask
  task automatic pop(input int n);
    check("pop_rdy", ready, 1);
    check("pop_data", data, mq[0]);
    void'(mq.pop_front());
    nextdata_n = 0;
    wn(n);
    nextdata_n = 1;
    wn(1);
  endtask
  task automatic state(input string tag);
    check({tag, "_rdy"}, ready, mq.size() != 0);
    if (mq.size() != 0) check({tag, "_data"}, data, mq[0]);
    check({tag, "_ovf"}, overflow, movf);
    check({tag, "_ferr"}, ferr_seen, ferr_exp);
  endtask
  task automatic do_reset();
    rst = 1;
    wn(2);
    rst = 0;
    wn(2);
    mq.delete();
    movf = 0;
  endtask
  initial begin
    wn(3);
    rst = 0;
    wn(3);
    check("rst_rdy", ready, 0);
    check("rst_ovf", overflow, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_data", data, 0);
    lat = 0;
    rx(8'h1C, 0, 0, 0, 0);
    check("latency", lat, S + 2);
    state("t1");
    pop(3);
    state("t1p");
    rx(8'h1C, 0, 0, 0, 0);
    rx(8'hF0, 0, 0, 0, 0);
    rx(8'h1C, 0, 0, 0, 0);
    state("t2");
    repeat (3) pop(3);
    state("t2d");
    nextdata_n = 0;
    wn(3);
    nextdata_n = 1;
    wn(2);
    state("epop");
    rx(8'h1C, 1, 0, 0, 0);
    state("t3");
    rx(8'h32, 0, 0, 0, 0);
    state("t3b");
    pop(3);
    for (int b = 1; b <= 9; b++) rx(8'(b), 0, 0, 0, 0);
    state("t4");
    repeat (8) pop(3);
    state("t4d");
    do_reset();
    for (int b = 1; b <= 8; b++) rx(8'(b), 0, 0, 0, 0);
    rx(8'h09, 0, 0, 0, 1);
    state("t5");
    check("t5_cnt", mq.size(), 8);
    check("t5_last", mq[7], 8'h09);
    while (mq.size() != 0) pop(2);
    state("t5d");
    send(mk(8'h55, 0, 0, 0), 5, 0);
    wn(TO + 20);
    ferr_exp++;
    state("t6");
    rx(8'h2A, 0, 0, 0, 0);
    state("t6b");
    pop(2);
    rx(8'h11, 0, 0, 0, 0);
    send(mk(8'h77, 0, 0, 0), 4, 0);
    do_reset();
    state("rstmid");
    rx(8'h3C, 0, 0, 0, 0);
    state("rstmid2");
    pop(2);
    do_reset();
    for (int k = 0; k < 60; k++) begin
      automatic logic [7:0] b = 8'($urandom);
      automatic int e = $urandom_range(0, 11);
      rx(b, e == 1, e == 2, e == 3, $urandom_range(0, 3) == 0);
      state("rnd");
      if (mq.size() != 0 && $urandom_range(0, 2) == 0) pop($urandom_range(1, 4));
    end
    while (mq.size() != 0) pop($urandom_range(1, 3));
    state("end");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
